// File: rtl/pdu_pkg.sv
// Shared constants for the PDU debug command controller: ASCII codes,
// 4-bit state encoding and the "no breakpoint" value.
package pdu_pkg;

  localparam logic [31:0] BP_NONE = 32'hFFFF_FFFF;

  localparam logic [7:0] CH_B    = 8'h42;
  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_K    = 8'h4B;
  localparam logic [7:0] CH_ERR  = 8'h3F;
  localparam logic [7:0] CH_STOP = 8'h21;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_SP   = 8'h20;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_BP_ADDR = 4'd1;
  localparam logic [3:0] S_TX_ACK  = 4'd2;
  localparam logic [3:0] S_TX_ERR  = 4'd3;
  localparam logic [3:0] S_TX_HEX  = 4'd4;
  localparam logic [3:0] S_TX_NL   = 4'd5;

  typedef enum logic [3:0] {
    ST_IDLE    = S_IDLE,
    ST_BP_ADDR = S_BP_ADDR,
    ST_TX_ACK  = S_TX_ACK,
    ST_TX_ERR  = S_TX_ERR,
    ST_TX_HEX  = S_TX_HEX,
    ST_TX_NL   = S_TX_NL
  } state_t;

  // Commands are case-insensitive; fold 'a'..'z' onto 'A'..'Z'.
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) ? (c & 8'hDF) : c;
  endfunction

endpackage

// File: rtl/pdu_cmd_ctrl_hex_codec.sv
// Combinational hex codec: ASCII hex digit -> nibble (with valid flag) and
// nibble -> uppercase ASCII hex digit.
module pdu_hex_codec (
  input  logic [7:0] asc_in,
  output logic [3:0] nib_out,
  output logic       nib_valid,
  input  logic [3:0] nib_in,
  output logic [7:0] asc_out
);

  always_comb begin
    nib_out   = 4'h0;
    nib_valid = 1'b0;
    if ((asc_in >= 8'h30) && (asc_in <= 8'h39)) begin
      nib_out   = asc_in[3:0];
      nib_valid = 1'b1;
    end else if (((asc_in >= 8'h41) && (asc_in <= 8'h46)) ||
                 ((asc_in >= 8'h61) && (asc_in <= 8'h66))) begin
      // 'A'/'a' have low nibble 1, so +9 lands on 10.
      nib_out   = asc_in[3:0] + 4'd9;
      nib_valid = 1'b1;
    end
  end

  always_comb begin
    if (nib_in < 4'd10) asc_out = {4'h3, nib_in};
    else                asc_out = 8'h37 + {4'h0, nib_in};
  end

endmodule

// File: rtl/pdu_cmd_ctrl.sv
// Debug command controller: parses UART command bytes, drives the pipeline
// breakpoint/run inputs and reports stops. `define PDU_STEP_EN adds single-step.
module pdu_cmd_ctrl
  import pdu_pkg::*;
#(
  parameter logic [31:0] BP_RESET   = BP_NONE,
  parameter int          HEX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        cpu_stop,
  input  logic [31:0] stop_pc,
  output logic [31:0] pdu_breakpoint,
  output logic        pdu_run,
  output logic        cmd_err
);

  // Handshakes: a byte moves on a rising clk edge where valid & ready are both
  // high; tx_data/tx_valid are pure functions of registered state, so a byte
  // offered stays unchanged until the transmitter takes it.

  localparam int CW = $clog2(HEX_DIGITS + 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0]   shift, shift_d;
  logic [31:0]   bp_user, bp_d;
  logic [31:0]   pc_sh, pc_d;
  logic [7:0]    lead, lead_d;
  logic          stop_q1, stop_q2, stop_edge;
  logic          stop_pend, pend_d;
  logic          run_d;
  logic          live;
  logic [7:0]    cmd;
  logic [3:0]    rx_nib;
  logic          rx_nib_ok;
  logic [7:0]    hex_asc;

`ifdef PDU_STEP_EN
  logic          step_active, step_d;
  logic [31:0]   step_bp, step_bp_d;
  assign pdu_breakpoint = step_active ? step_bp : bp_user;
`else
  assign pdu_breakpoint = bp_user;
`endif

  assign stop_edge = stop_q1 & ~stop_q2;
  assign cmd       = to_upper(rx_data);

  pdu_hex_codec u_codec (
    .asc_in    (rx_data),
    .nib_out   (rx_nib),
    .nib_valid (rx_nib_ok),
    .nib_in    (pc_sh[31:28]),
    .asc_out   (hex_asc)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    shift_d  = shift;
    bp_d     = bp_user;
    pc_d     = pc_sh;
    lead_d   = lead;
    pend_d   = stop_pend | stop_edge;
    run_d    = 1'b0;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
`ifdef PDU_STEP_EN
    step_d    = step_active & ~stop_edge;
    step_bp_d = step_bp;
`endif
    case (state)
      ST_IDLE: begin
        if (stop_edge || stop_pend) begin
          // A stop report outranks any waiting command byte.
          pend_d  = 1'b0;
          pc_d    = stop_pc;
          lead_d  = CH_STOP;
          cnt_d   = '0;
          state_d = ST_TX_HEX;
        end else if (live) begin
          rx_ready = 1'b1;
          if (rx_valid) begin
            case (cmd)
              CH_B: begin
                cnt_d   = '0;
                shift_d = '0;
                state_d = ST_BP_ADDR;
              end
              CH_C: begin
                bp_d    = BP_RESET;
                state_d = ST_TX_ACK;
              end
              CH_R: begin
                if (cpu_stop) begin
                  run_d   = 1'b1;
                  state_d = ST_TX_ACK;
                end else begin
                  state_d = ST_TX_ERR;
                end
              end
              CH_P: begin
                pc_d    = stop_pc;
                lead_d  = CH_EQ;
                cnt_d   = '0;
                state_d = ST_TX_HEX;
              end
`ifdef PDU_STEP_EN
              CH_S: begin
                if (cpu_stop) begin
                  step_d    = 1'b1;
                  step_bp_d = stop_pc + 32'd4;
                  run_d     = 1'b1;
                  state_d   = ST_TX_ACK;
                end else begin
                  state_d = ST_TX_ERR;
                end
              end
`endif
              CH_CR, CH_LF, CH_SP: begin
                state_d = ST_IDLE;
              end
              default: state_d = ST_TX_ERR;
            endcase
          end
        end
      end
      ST_BP_ADDR: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (!rx_nib_ok) begin
            state_d = ST_TX_ERR;
          end else if (cnt == CW'(HEX_DIGITS - 1)) begin
            bp_d    = {shift[27:0], rx_nib};
            state_d = ST_TX_ACK;
          end else begin
            shift_d = {shift[27:0], rx_nib};
            cnt_d   = cnt + 1'b1;
          end
        end
      end
      ST_TX_ACK: begin
        tx_valid = 1'b1;
        tx_data  = CH_K;
        if (tx_ready) state_d = ST_TX_NL;
      end
      ST_TX_ERR: begin
        tx_valid = 1'b1;
        tx_data  = CH_ERR;
        if (tx_ready) state_d = ST_TX_NL;
      end
      ST_TX_HEX: begin
        // cnt==0 is the lead character; digits then shift out of pc_sh MSB first.
        tx_valid = 1'b1;
        tx_data  = (cnt == '0) ? lead : hex_asc;
        if (tx_ready) begin
          if (cnt == '0) begin
            cnt_d = cnt + 1'b1;
          end else begin
            pc_d = {pc_sh[27:0], 4'h0};
            if (cnt == CW'(HEX_DIGITS)) state_d = ST_TX_NL;
            else                        cnt_d   = cnt + 1'b1;
          end
        end
      end
      ST_TX_NL: begin
        tx_valid = 1'b1;
        tx_data  = CH_LF;
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shift     <= '0;
      bp_user   <= BP_RESET;
      pc_sh     <= '0;
      lead      <= 8'h00;
      stop_q1   <= 1'b0;
      stop_q2   <= 1'b0;
      stop_pend <= 1'b0;
      pdu_run   <= 1'b0;
      cmd_err   <= 1'b0;
      live      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      shift     <= shift_d;
      bp_user   <= bp_d;
      pc_sh     <= pc_d;
      lead      <= lead_d;
      stop_q1   <= cpu_stop;
      stop_q2   <= stop_q1;
      stop_pend <= pend_d;
      pdu_run   <= run_d;
      cmd_err   <= (state_d == ST_TX_ERR) && (state != ST_TX_ERR);
      live      <= 1'b1;
    end
  end

`ifdef PDU_STEP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_active <= 1'b0;
      step_bp     <= BP_RESET;
    end else begin
      step_active <= step_d;
      step_bp     <= step_bp_d;
    end
  end
`endif

endmodule

// File: tb/tb_pdu_cmd_ctrl.sv
// Self-checking bench for pdu_cmd_ctrl: command driver, tx scoreboard fed by
// an expected-byte queue, pulse counters and a final report.
module tb_pdu_cmd_ctrl;

  logic        clk;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cpu_stop;
  logic [31:0] stop_pc;
  logic [31:0] pdu_breakpoint;
  logic        pdu_run;
  logic        cmd_err;

  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int run_cnt = 0;
  int err_cnt = 0;
  logic prev_run = 1'b0;
  logic tx_hold  = 1'b0;

  pdu_cmd_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .cpu_stop       (cpu_stop),
    .stop_pc        (stop_pc),
    .pdu_breakpoint (pdu_breakpoint),
    .pdu_run        (pdu_run),
    .cmd_err        (cmd_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // transmitter with random backpressure, forced low while tx_hold is set
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = tx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // scoreboard: every offered byte must match the queue head
  always @(negedge clk) begin
    if (tx_valid) begin
      check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q[0]});
        if (tx_ready) void'(exp_q.pop_front());
      end
    end
    if (pdu_run) check("run_single_cycle", {31'd0, prev_run}, 32'd0);
    prev_run = pdu_run;
    if (pdu_run) run_cnt++;
    if (cmd_err) err_cnt++;
  end

  // driver tasks
  task automatic push_ack();
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_err();
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_hex(input logic [7:0] lead, input logic [31:0] v);
    logic [3:0] n;
    exp_q.push_back(lead);
    for (int i = 7; i >= 0; i--) begin
      n = v[i*4 +: 4];
      if (n < 4'd10) exp_q.push_back(8'h30 + {4'd0, n});
      else           exp_q.push_back(8'h41 + {4'd0, n} - 8'd10);
    end
    exp_q.push_back(8'h0A);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_ready && n < 200);
    check("rx_accept", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rv;
    int r0, e0;
    rstn     = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    cpu_stop = 1'b0;
    stop_pc  = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_bp", pdu_breakpoint, 32'hFFFF_FFFF);
    check("rst_run", {31'd0, pdu_run}, 32'd0);
    check("rst_err", {31'd0, cmd_err}, 32'd0);
    check("rst_txv", {31'd0, tx_valid}, 32'd0);
    check("rst_txd", {24'd0, tx_data}, 32'd0);
    check("rst_rxr", {31'd0, rx_ready}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // invalid digit aborts the breakpoint command
    e0 = err_cnt;
    push_err();
    send_str("B12G");
    drain();
    check("bad_digit_err", err_cnt - e0, 32'd1);
    check("bad_digit_bp", pdu_breakpoint, 32'hFFFF_FFFF);
    push_ack();
    send_str("c");
    drain();

    // whitespace is ignored, unknown command rejected
    send_str(" \r\n");
    drain();
    e0 = err_cnt;
    push_err();
    send_str("X");
    drain();
    check("unknown_err", err_cnt - e0, 32'd1);

    // breakpoint load with timing of the update
    push_ack();
    send_str("B0000F00");
    check("bp_before_last", pdu_breakpoint, 32'hFFFF_FFFF);
    send_byte("C");
    check("bp_loaded", pdu_breakpoint, 32'h0000_F00C);
    drain();

    for (int k = 0; k < 2; k++) begin
      rv = $urandom();
      rv[1:0] = 2'b00;
      push_ack();
      send_str($sformatf("b%08x", rv));
      check("bp_random", pdu_breakpoint, rv);
      drain();
    end

    // stop report
    stop_pc  = 32'h0000_3004;
    cpu_stop = 1'b1;
    push_hex(8'h21, 32'h0000_3004);
    drain();

    // run gating
    r0 = run_cnt;
    push_ack();
    send_byte("R");
    check("run_pulse", {31'd0, pdu_run}, 32'd1);
    drain();
    check("run_count", run_cnt - r0, 32'd1);
    cpu_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    r0 = run_cnt;
    e0 = err_cnt;
    push_err();
    send_byte("r");
    drain();
    check("run_blocked", run_cnt - r0, 32'd0);
    check("run_blocked_err", err_cnt - e0, 32'd1);

    // backpressure during a PC dump, with a stop arriving mid-dump
    stop_pc = 32'h89AB_CDEF;
    tx_hold = 1'b1;
    push_hex(8'h3D, 32'h89AB_CDEF);
    send_byte("P");
    repeat (5) @(posedge clk);
    #1;
    stop_pc  = 32'h0000_4008;
    cpu_stop = 1'b1;
    push_hex(8'h21, 32'h0000_4008);
    repeat (15) @(posedge clk);
    #1;
    check("hold_txv", {31'd0, tx_valid}, 32'd1);
    check("hold_txd", {24'd0, tx_data}, 32'h3D);
    tx_hold = 1'b0;
    drain();

    // reset in the middle of a breakpoint command
    cpu_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_str("B12");
    rstn = 1'b0;
    #1;
    check("midrst_bp", pdu_breakpoint, 32'hFFFF_FFFF);
    check("midrst_rxr", {31'd0, rx_ready}, 32'd0);
    check("midrst_txv", {31'd0, tx_valid}, 32'd0);
    check("midrst_txd", {24'd0, tx_data}, 32'd0);
    check("midrst_run", {31'd0, pdu_run}, 32'd0);
    check("midrst_err", {31'd0, cmd_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    stop_pc = 32'h0000_5550;
    push_hex(8'h3D, 32'h0000_5550);
    send_byte("P");
    drain();

`ifdef PDU_STEP_EN
    stop_pc  = 32'h0000_0100;
    cpu_stop = 1'b1;
    push_hex(8'h21, 32'h0000_0100);
    drain();
    push_ack();
    send_byte("S");
    check("step_run", {31'd0, pdu_run}, 32'd1);
    check("step_bp", pdu_breakpoint, 32'h0000_0104);
    drain();
    cpu_stop = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("step_bp_hold", pdu_breakpoint, 32'h0000_0104);
    stop_pc  = 32'h0000_0104;
    cpu_stop = 1'b1;
    push_hex(8'h21, 32'h0000_0104);
    drain();
    check("step_bp_restore", pdu_breakpoint, 32'hFFFF_FFFF);
`else
    e0 = err_cnt;
    push_err();
    send_byte("S");
    drain();
    check("step_unknown_err", err_cnt - e0, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
